// File: rtl/sol32_pkg.sv
// sol32_pkg
//   Shared types and default widths for the sol32 memory-side blocks.
//   arb_state_t : arbiter FSM states
//   owner_t     : which requester owns the transaction in flight
package sol32_pkg;

  localparam int unsigned SOL32_ADDR_W = 32;
  localparam int unsigned SOL32_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/sol32_arb_watchdog.sv
// sol32_arb_watchdog
//   Cycle counter that flags when it has counted LIMIT enabled cycles
//   since the last clear. LIMIT = 0 disables the expire output.
//   Clock  : rising-edge clock
//   Reset  : asynchronous active-high reset
//   Clear  : synchronous clear of the count (wins over Enable)
//   Enable : count this cycle
//   Expire : count has reached LIMIT while enabled
module sol32_arb_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  input  logic Enable,
  output logic Expire
);

  localparam int unsigned CW = $clog2(LIMIT + 2);

  logic [CW-1:0] count;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (Clear) begin
      count <= '0;
    end else if (Enable && (count != CW'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  always_comb begin
    Expire = (LIMIT != 0) && Enable && (count == CW'(LIMIT));
  end

endmodule

// File: rtl/sol32_mem_arbiter.sv
// sol32_mem_arbiter
//   Shares one memory port between instruction fetch (If*) and load/store
//   (D*). One transaction at a time; data side has priority, but after
//   MAX_DATA_STREAK consecutive data grants with a fetch waiting, fetch wins.
//   A watchdog ends a WAIT that exceeds TIMEOUT cycles with BusError.
//   Clock/Reset        : rising-edge clock, async active-high reset
//   IfReq/IfAddr       : fetch request; IfAccept/IfValid pulses back
//   DReq/DWrite/DAddr/DWData : data request; DAccept/DValid pulses back
//   RData/BusError     : shared response data, watchdog termination flag
//   Mem*               : unified memory port (req/ready, valid/rdata)
module sol32_mem_arbiter
  import sol32_pkg::*;
#(
  parameter int unsigned ADDR_W          = SOL32_ADDR_W,
  parameter int unsigned DATA_W          = SOL32_DATA_W,
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT         = 255
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              IfReq,
  input  logic [ADDR_W-1:0] IfAddr,
  output logic              IfAccept,
  output logic              IfValid,
  input  logic              DReq,
  input  logic              DWrite,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWData,
  output logic              DAccept,
  output logic              DValid,
  output logic [DATA_W-1:0] RData,
  output logic              BusError,
  output logic              MemReq,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic              MemReady,
  input  logic              MemValid,
  input  logic [DATA_W-1:0] MemRData
);

  localparam int unsigned SW = $clog2(MAX_DATA_STREAK + 2);

  arb_state_t        state;
  owner_t            owner;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic [SW-1:0]     dstreak;

  logic grant_d;
  logic grant_if;
  logic expire;
  logic wait_done;

  sol32_arb_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .Clock  (Clock),
    .Reset  (Reset),
    .Clear  (state != WAIT),
    .Enable (state == WAIT),
    .Expire (expire)
  );

  always_comb begin
    grant_d   = DReq && !(IfReq && (dstreak == SW'(MAX_DATA_STREAK)));
    grant_if  = !grant_d && IfReq;
    wait_done = (state == WAIT) && (MemValid || expire);

    // Accept is combinational from the requests, so it is masked while
    // Reset is held to keep every output low during reset.
    DAccept  = !Reset && (state == IDLE) && grant_d;
    IfAccept = !Reset && (state == IDLE) && grant_if;

    DValid   = wait_done && (owner == OWNER_D);
    IfValid  = wait_done && (owner == OWNER_IF);
    BusError = (state == WAIT) && !MemValid && expire;
    RData    = ((state == WAIT) && MemValid) ? MemRData : '0;

    MemReq   = (state == ISSUE);
    MemWrite = (state == ISSUE) && write_q;
    MemAddr  = addr_q;
    MemWData = wdata_q;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      owner   <= OWNER_IF;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      dstreak <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner   <= OWNER_D;
            addr_q  <= DAddr;
            wdata_q <= DWData;
            write_q <= DWrite;
            state   <= ISSUE;
            if (!IfReq) begin
              dstreak <= '0;
            end else if (dstreak != SW'(MAX_DATA_STREAK)) begin
              dstreak <= dstreak + 1'b1;
            end
          end else if (grant_if) begin
            owner   <= OWNER_IF;
            addr_q  <= IfAddr;
            wdata_q <= '0;
            write_q <= 1'b0;
            dstreak <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (MemReady) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wait_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sol32_mem_arbiter.sv
module tb_sol32_mem_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        IfReq = 1'b0;
  logic [31:0] IfAddr = '0;
  logic        IfAccept;
  logic        IfValid;
  logic        DReq = 1'b0;
  logic        DWrite = 1'b0;
  logic [31:0] DAddr = '0;
  logic [31:0] DWData = '0;
  logic        DAccept;
  logic        DValid;
  logic [31:0] RData;
  logic        BusError;
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        MemReady = 1'b0;
  logic        MemValid = 1'b0;
  logic [31:0] MemRData = '0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  sol32_mem_arbiter #(
    .ADDR_W          (32),
    .DATA_W          (32),
    .MAX_DATA_STREAK (4),
    .TIMEOUT         (8)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .IfReq    (IfReq),
    .IfAddr   (IfAddr),
    .IfAccept (IfAccept),
    .IfValid  (IfValid),
    .DReq     (DReq),
    .DWrite   (DWrite),
    .DAddr    (DAddr),
    .DWData   (DWData),
    .DAccept  (DAccept),
    .DValid   (DValid),
    .RData    (RData),
    .BusError (BusError),
    .MemReq   (MemReq),
    .MemWrite (MemWrite),
    .MemAddr  (MemAddr),
    .MemWData (MemWData),
    .MemReady (MemReady),
    .MemValid (MemValid),
    .MemRData (MemRData)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs checked 2 time units later, well away from either edge.
  task automatic cyc;
    @(posedge Clock);
    #1;
  endtask

  // Runs ISSUE (MemReady on first cycle) and WAIT (MemValid on first cycle)
  // for a transaction just accepted; returns at the start of the next IDLE.
  task automatic txn(input string tag, input logic exp_if, input logic [31:0] exp_addr,
                     input logic [31:0] rd, input logic keep_if, input logic keep_d);
    cyc();
    if (!keep_if) IfReq = 1'b0;
    if (!keep_d) DReq = 1'b0;
    MemReady = 1'b1;
    #2;
    chk({tag, "_memreq"}, {31'd0, MemReq}, 32'd1);
    chk({tag, "_memaddr"}, MemAddr, exp_addr);
    chk({tag, "_noacc"}, {30'd0, IfAccept, DAccept}, 32'd0);
    cyc();
    MemReady = 1'b0;
    MemValid = 1'b1;
    MemRData = rd;
    #2;
    chk({tag, "_valid"}, {30'd0, IfValid, DValid}, exp_if ? 32'd2 : 32'd1);
    chk({tag, "_rdata"}, RData, rd);
    cyc();
    MemValid = 1'b0;
  endtask

  logic grant_seq [6];

  initial begin
    // ---- reset state
    #2;
    chk("rst_memreq", {31'd0, MemReq}, 32'd0);
    chk("rst_outs", {26'd0, IfAccept, IfValid, DAccept, DValid, BusError, MemWrite}, 32'd0);
    chk("rst_memaddr", MemAddr, 32'd0);
    cyc();
    cyc();
    Reset = 1'b0;
    cyc();

    // ---- single load, one stall cycle on MemReady
    DReq = 1'b1; DAddr = 32'h100; DWrite = 1'b0;
    #2;
    chk("ld_daccept", {31'd0, DAccept}, 32'd1);
    chk("ld_ifaccept", {31'd0, IfAccept}, 32'd0);
    chk("ld_c0_memreq", {31'd0, MemReq}, 32'd0);
    cyc();
    DReq = 1'b0;
    #2;
    chk("ld_c1_memreq", {31'd0, MemReq}, 32'd1);
    chk("ld_c1_addr", MemAddr, 32'h100);
    chk("ld_c1_write", {31'd0, MemWrite}, 32'd0);
    cyc();
    MemReady = 1'b1;
    #2;
    chk("ld_c2_memreq", {31'd0, MemReq}, 32'd1);
    cyc();
    MemReady = 1'b0; MemValid = 1'b1; MemRData = 32'hDEADBEEF;
    #2;
    chk("ld_c3_memreq", {31'd0, MemReq}, 32'd0);
    chk("ld_c3_dvalid", {31'd0, DValid}, 32'd1);
    chk("ld_c3_ifvalid", {31'd0, IfValid}, 32'd0);
    chk("ld_c3_rdata", RData, 32'hDEADBEEF);
    chk("ld_c3_buserr", {31'd0, BusError}, 32'd0);
    cyc();
    MemValid = 1'b0;
    #2;
    chk("ld_c4_dvalid", {31'd0, DValid}, 32'd0);
    cyc();

    // ---- simultaneous requests: D first, then IF
    IfReq = 1'b1; IfAddr = 32'h200; DReq = 1'b1; DAddr = 32'h300;
    #2;
    chk("sim_acc1", {30'd0, IfAccept, DAccept}, 32'd1);
    txn("sim_d", 1'b0, 32'h300, 32'h0000A5A5, 1'b1, 1'b0);
    #2;
    chk("sim_acc2", {30'd0, IfAccept, DAccept}, 32'd2);
    txn("sim_if", 1'b1, 32'h200, 32'h00005A5A, 1'b0, 1'b0);

    // ---- starvation guard: both held, expect D D D D IF D
    grant_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    IfReq = 1'b1; IfAddr = 32'h400; DReq = 1'b1; DAddr = 32'h500;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk($sformatf("starv_grant%0d", i), {30'd0, IfAccept, DAccept},
          grant_seq[i] ? 32'd2 : 32'd1);
      txn($sformatf("starv_t%0d", i), grant_seq[i], grant_seq[i] ? 32'h400 : 32'h500,
          32'h1000 + i, 1'b1, 1'b1);
    end
    IfReq = 1'b0; DReq = 1'b0;
    cyc();

    // ---- store with three MemReady stall cycles
    DReq = 1'b1; DWrite = 1'b1; DAddr = 32'h40; DWData = 32'h12345678;
    #2;
    chk("st_daccept", {31'd0, DAccept}, 32'd1);
    cyc();
    DReq = 1'b0; DWrite = 1'b0; DAddr = '0; DWData = '0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("st_stall%0d_ctl", i), {30'd0, MemReq, MemWrite}, 32'd3);
      chk($sformatf("st_stall%0d_addr", i), MemAddr, 32'h40);
      chk($sformatf("st_stall%0d_wdata", i), MemWData, 32'h12345678);
      cyc();
    end
    MemReady = 1'b1;
    #2;
    chk("st_ready_ctl", {30'd0, MemReq, MemWrite}, 32'd3);
    cyc();
    MemReady = 1'b0;
    #2;
    chk("st_wait_dvalid0", {31'd0, DValid}, 32'd0);
    cyc();
    MemValid = 1'b1;
    #2;
    chk("st_dvalid", {30'd0, IfValid, DValid}, 32'd1);
    cyc();
    MemValid = 1'b0;

    // ---- watchdog: no MemValid, terminate on 9th WAIT cycle (count 8)
    DReq = 1'b1; DAddr = 32'h80; MemRData = 32'hCAFEF00D;
    #2;
    chk("wd_daccept", {31'd0, DAccept}, 32'd1);
    cyc();
    DReq = 1'b0; MemReady = 1'b1;
    cyc();
    MemReady = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #2;
      chk($sformatf("wd_wait%0d", k), {30'd0, DValid, BusError}, 32'd0);
      cyc();
    end
    #2;
    chk("wd_expire", {30'd0, DValid, BusError}, 32'd3);
    chk("wd_rdata", RData, 32'd0);
    cyc();
    cyc();
    MemValid = 1'b1;
    #2;
    chk("wd_late_valid", {30'd0, IfValid, DValid}, 32'd0);
    cyc();
    MemValid = 1'b0;

    // ---- asynchronous reset while in WAIT
    DReq = 1'b1; DAddr = 32'h600;
    #2;
    chk("mr_daccept", {31'd0, DAccept}, 32'd1);
    cyc();
    MemReady = 1'b1;
    cyc();
    MemReady = 1'b0;
    #2;
    chk("mr_inwait_memreq", {31'd0, MemReq}, 32'd0);
    Reset = 1'b1;
    MemValid = 1'b1; MemRData = 32'h77777777;
    #1;
    chk("mr_outs", {26'd0, IfAccept, IfValid, DAccept, DValid, BusError, MemReq}, 32'd0);
    chk("mr_addr", MemAddr, 32'd0);
    chk("mr_rdata", RData, 32'd0);
    cyc();
    DReq = 1'b0; MemValid = 1'b0;
    cyc();
    Reset = 1'b0;
    IfReq = 1'b1; IfAddr = 32'h700;
    #2;
    chk("mr_ifaccept", {30'd0, IfAccept, DAccept}, 32'd2);
    txn("mr_if", 1'b1, 32'h700, 32'h0BADC0DE, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sol32_mem_arbiter.md
Name: sol32_mem_arbiter

Overview:
Shares one unified memory port between the sol32 core's instruction-fetch side and its load/store side, so the core can run on a single-port RAM.
- One transaction outstanding at a time.
- Data accesses have priority; a streak counter guarantees fetch forward progress.
- A watchdog terminates memory transactions that hang.
- Sits between sol32core and the memory/bus interface; also the natural insertion point for later core stall logic.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is pending before fetch is forced
TIMEOUT, 255, max cycles in WAIT before forced termination; 0 disables the watchdog

Ports:
Clock  in  1  single clock, rising edge
Reset  in  1  asynchronous, active-high reset
IfReq  in  1  fetch request, held until IfAccept
IfAddr  in  ADDR_W  fetch address
IfAccept  out  1  one-cycle pulse: fetch request latched
IfValid  out  1  one-cycle pulse: fetch data on RData
DReq  in  1  data request, held until DAccept
DWrite  in  1  1 = store, 0 = load
DAddr  in  ADDR_W  data address
DWData  in  DATA_W  store data
DAccept  out  1  one-cycle pulse: data request latched
DValid  out  1  one-cycle pulse: load data on RData / store complete
RData  out  DATA_W  response data, shared by both requesters
BusError  out  1  one-cycle pulse alongside IfValid/DValid when the watchdog fired
MemReq  out  1  memory request
MemWrite  out  1  memory write strobe
MemAddr  out  ADDR_W  memory address
MemWData  out  DATA_W  memory write data
MemReady  in  1  memory accepts the request this cycle
MemValid  in  1  memory response/completion this cycle
MemRData  in  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, ISSUE, WAIT.
- Latched registers: Owner (IF/D), address, write data, write flag, DStreak counter, timeout counter.
- Reset (asynchronous, any state): FSM to IDLE, all latched registers and counters to 0, all outputs 0. MemReq drops the same instant. An in-flight memory transaction is abandoned, and no Valid is issued for it.

IDLE:
- If either request is high, pick a winner, latch its fields, and pulse its Accept combinationally in this cycle; next state ISSUE.
- Winner rule:
  - D wins if DReq, unless IfReq && DStreak == MAX_DATA_STREAK.
  - Otherwise IF wins if IfReq.
- DStreak update:
  - D granted while IfReq is high: increment, saturating.
  - IF granted, or IfReq low at arbitration: clear to 0.

ISSUE:
- MemReq = 1; MemAddr, MemWData and MemWrite come from the latched fields and are stable until MemReady.
- On MemReady, go to WAIT.
- The requester's inputs are don't-care from this point on.

WAIT:
- MemReq = 0; the timeout counter increments each cycle.
- On MemValid:
  - RData = MemRData; the owner's Valid is pulsed combinationally in this cycle.
  - For stores, the Valid is still pulsed and RData is don't-care.
  - Next state IDLE.
- If TIMEOUT != 0 and the counter reaches TIMEOUT without MemValid:
  - Pulse the owner's Valid with BusError = 1 and RData = 0; next state IDLE.
- A late MemValid arriving after a timeout is ignored.

General rules:
- MemValid is ignored outside WAIT. Valid and Accept never go to the non-owner.
- Minimum transaction time is 3 cycles (IDLE to ISSUE to WAIT) when MemReady and MemValid are each high on the first cycle they are sampled. The next arbitration happens in the IDLE cycle that follows.
- Both requests may be high simultaneously; the winner rule applies. The loser keeps its request asserted and gets no Accept.
- A requester dropping its Req before Accept is legal; nothing is latched for it.

Decomposition:
- Shared package sol32_pkg: the arb_state_t enum (IDLE/ISSUE/WAIT), the owner_t enum (OWNER_IF/OWNER_D), and the default width constants.
- One sub-module, sol32_arb_watchdog: a timeout counter with clear/enable inputs and an expire output, reused later for the interrupt path.
- All other logic is the single FSM in sol32_mem_arbiter.

Test Plan:
- Single load: DReq=1, DAddr=0x100, with MemReady and MemValid each one cycle after their request and MemRData=0xDEADBEEF. Required: DAccept in cycle 0, MemReq in cycle 1, DValid with RData=0xDEADBEEF in cycle 3, IfValid never asserted.
- Simultaneous requests: IfReq=DReq=1 in IDLE. Required: D granted first and IF granted at the next IDLE; MemAddr sequence is DAddr then IfAddr.
- Starvation guard (MAX_DATA_STREAK=4): IfReq and DReq both held high. Required: grant order D, D, D, D, IF, D, …, with DStreak at 0 after the IF grant.
- Store: DWrite=1, DAddr=0x40, DWData=0x12345678. Required: MemWrite=1 with address and data stable through 3 stall cycles of MemReady=0; DValid pulses on MemValid.
- Watchdog (TIMEOUT=8): MemValid held low. Required: DValid and BusError together, 8 cycles after entering WAIT, with RData=0. A MemValid injected 2 cycles later produces no Valid.
- Mid-transaction reset: assert Reset while in WAIT. Required: all outputs 0 immediately (asynchronous). After release, a new IfReq is accepted and serviced normally.
